// File: rtl/stack_pkg.sv
// Stack command encoding shared by the control unit and the data/return/proc stack units.
package stack_pkg;

    typedef logic [2:0] stack_action_t;

    localparam stack_action_t SA_NOP     = 3'b000;
    localparam stack_action_t SA_POP     = 3'b001;
    localparam stack_action_t SA_DROP    = 3'b010;
    localparam stack_action_t SA_REPLACE = 3'b011;
    localparam stack_action_t SA_PUSH    = 3'b100;
    localparam stack_action_t SA_DUP     = 3'b101;
    localparam stack_action_t SA_RSVD    = 3'b110;
    localparam stack_action_t SA_SWAP    = 3'b111;

endpackage

// File: rtl/stack_guard.sv
// Pure legality check of a stack command against the current depth.
// ovf/unf flag the two failure kinds; the reserved code is illegal without setting either.
module stack_guard
    import stack_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned DW   = $clog2(DEPTH + 1)
) (
    input  stack_action_t   action,
    input  logic [DW-1:0]   depth,
    output logic            legal,
    output logic            ovf,
    output logic            unf
);

    localparam logic [DW-1:0] DepthMax = DW'(DEPTH);

    logic is_empty;
    logic is_full;

    assign is_empty = (depth == '0);
    assign is_full  = (depth == DepthMax);

    always_comb begin
        ovf = 1'b0;
        unf = 1'b0;
        case (action)
            SA_POP, SA_DROP, SA_REPLACE: unf = is_empty;
            SA_PUSH:                     ovf = is_full;
            SA_DUP: begin
                unf = is_empty;
                ovf = is_full;
            end
            SA_SWAP:                     unf = (depth < DW'(2));
            default: ;
        endcase
    end

    assign legal = !ovf && !unf && (action != SA_RSVD);

endmodule

// File: rtl/data_stack_unit.sv
// Register-based data stack driven by dStackAction. Entry 0 is the top; vacated slots are
// zeroed so top/next read 0 below their depth. Define DSTACK_PEEK_EN for the peek port.
module data_stack_unit
    import stack_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned DW   = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [2:0]       dStackAction,
    input  logic [WIDTH-1:0] dIn,
    output logic [WIDTH-1:0] top,
    output logic [WIDTH-1:0] next,
    output logic [WIDTH-1:0] popped,
    output logic [DW-1:0]    depth,
    output logic             empty,
    output logic             full,
    output logic             err_pulse,
    output logic             err_overflow,
    output logic             err_underflow
`ifdef DSTACK_PEEK_EN
    ,
    input  logic [DW-1:0]    peek_idx,
    output logic [WIDTH-1:0] peek_data
`endif
);

    logic [WIDTH-1:0] entry_q [DEPTH];
    logic [WIDTH-1:0] entry_d [DEPTH];
    logic [DW-1:0]    depth_q, depth_d;
    logic [WIDTH-1:0] popped_q, popped_d;
    logic             err_pulse_q, ovf_q, unf_q;
    logic             legal, ovf, unf;
    stack_action_t    action;

    assign action = stack_action_t'(dStackAction);

    stack_guard #(
        .DEPTH (DEPTH)
    ) u_guard (
        .action (action),
        .depth  (depth_q),
        .legal  (legal),
        .ovf    (ovf),
        .unf    (unf)
    );

    always_comb begin
        entry_d  = entry_q;
        depth_d  = depth_q;
        popped_d = popped_q;
        if (legal) begin
            case (action)
                SA_POP, SA_DROP: begin
                    if (action == SA_POP) popped_d = entry_q[0];
                    for (int i = 0; i < DEPTH - 1; i++) entry_d[i] = entry_q[i+1];
                    entry_d[DEPTH-1] = '0;
                    depth_d = depth_q - DW'(1);
                end
                SA_REPLACE: entry_d[0] = dIn;
                SA_PUSH, SA_DUP: begin
                    for (int i = 1; i < DEPTH; i++) entry_d[i] = entry_q[i-1];
                    entry_d[0] = (action == SA_PUSH) ? dIn : entry_q[0];
                    depth_d = depth_q + DW'(1);
                end
                SA_SWAP: begin
                    entry_d[0] = entry_q[1];
                    entry_d[1] = entry_q[0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
            depth_q     <= '0;
            popped_q    <= '0;
            err_pulse_q <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            entry_q     <= entry_d;
            depth_q     <= depth_d;
            popped_q    <= popped_d;
            err_pulse_q <= !legal;
            ovf_q       <= ovf_q | ovf;
            unf_q       <= unf_q | unf;
        end
    end

    assign top           = entry_q[0];
    assign next          = entry_q[1];
    assign popped        = popped_q;
    assign depth         = depth_q;
    assign empty         = (depth_q == '0);
    assign full          = (depth_q == DW'(DEPTH));
    assign err_pulse     = err_pulse_q;
    assign err_overflow  = ovf_q;
    assign err_underflow = unf_q;

`ifdef DSTACK_PEEK_EN
    always_comb begin
        peek_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((DW'(i) == peek_idx) && (peek_idx < depth_q)) peek_data = entry_q[i];
        end
    end
`endif

endmodule
